// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, EX/MEM opcodes,
// FSM state encoding and opcode decode helpers.
package mem_stage_pkg;

  localparam int unsigned REG_BUS      = 32;
  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned ALU_OP_BUS   = 8;

  typedef logic [ALU_OP_BUS-1:0] aluop_t;

  localparam aluop_t EX_NOP = 8'h00;
  localparam aluop_t EX_LB  = 8'h20;
  localparam aluop_t EX_LH  = 8'h21;
  localparam aluop_t EX_LW  = 8'h22;
  localparam aluop_t EX_LBU = 8'h24;
  localparam aluop_t EX_LHU = 8'h25;
  localparam aluop_t EX_SB  = 8'h28;
  localparam aluop_t EX_SH  = 8'h29;
  localparam aluop_t EX_SW  = 8'h2A;

  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {IDLE, XFER, LAST, DONE} state_t;

  function automatic logic is_load(input aluop_t op);
    return op inside {EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU};
  endfunction

  function automatic logic is_store(input aluop_t op);
    return op inside {EX_SB, EX_SH, EX_SW};
  endfunction

  // Index of the final byte of the transfer (transfer length minus one)
  function automatic logic [1:0] last_idx(input aluop_t op);
    logic [1:0] idx;
    case (op)
      EX_LB, EX_LBU, EX_SB: idx = 2'd0;
      EX_LH, EX_LHU, EX_SH: idx = 2'd1;
      default:              idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Shared 8-bit memory port between the MEM stage and the IF/MEM arbiter.
interface mem_stage_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        wr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (output req, addr, wr, wdata, input gnt, rdata);
  modport slave  (input req, addr, wr, wdata, output gnt, rdata);
endinterface

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of the assembled load result.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  aluop_t             op,
  input  logic [REG_BUS-1:0] raw,
  output logic [REG_BUS-1:0] ext_c
);
  always_comb begin
    ext_c = raw;
    case (op)
      EX_LB:   ext_c = {{24{raw[7]}}, raw[7:0]};
      EX_LBU:  ext_c = {24'h0, raw[7:0]};
      EX_LH:   ext_c = {{16{raw[15]}}, raw[15:0]};
      EX_LHU:  ext_c = {16'h0, raw[15:0]};
      default: ext_c = raw;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over the shared 8-bit port,
// zero-latency pass-through for non-memory ops.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  aluop_t                  aluop_i,
  input  logic [REG_BUS-1:0]      mem_addr_i,
  input  logic [REG_BUS-1:0]      w_data_i,
  input  logic [REG_ADDR_BUS-1:0] w_addr_i,
  input  logic                    w_req_i,
  output logic [REG_ADDR_BUS-1:0] w_addr_o,
  output logic                    w_req_o,
  output logic [REG_BUS-1:0]      w_data_o,
  output logic                    stall_req_o,
  mem_stage_if.master             bus
);

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q;
  aluop_t                  op_q;
  logic [REG_BUS-1:0]      base_q, data_q, res_q, ext;
  logic [REG_ADDR_BUS-1:0] waddr_q;
  logic                    wreq_q;
  logic                    mem_op, last_byte;
  logic [4:0]              cap_idx;

  assign mem_op    = is_load(aluop_i) || is_store(aluop_i);
  assign last_byte = (cnt_q == last_idx(op_q));
  // Read data lags its address by one cycle, so capture targets the previous byte
  assign cap_idx   = (state_q == LAST) ? {last_idx(op_q), 3'b000}
                                       : {2'(cnt_q - 2'd1), 3'b000};

  mem_stage_load_ext u_load_ext (
    .op    (op_q),
    .raw   (res_q),
    .ext_c (ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Transfer latches, byte counter and load assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      op_q    <= EX_NOP;
      base_q  <= '0;
      data_q  <= '0;
      waddr_q <= NOP_REG_ADDR;
      wreq_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (mem_op && bus.gnt) begin
          cnt_q   <= 2'd0;
          op_q    <= aluop_i;
          base_q  <= mem_addr_i;
          data_q  <= w_data_i;
          waddr_q <= w_addr_i;
          wreq_q  <= w_req_i;
          res_q   <= '0;
        end
        XFER: begin
          if (cnt_q != 2'd0 && is_load(op_q)) res_q[cap_idx +: 8] <= bus.rdata;
          if (!last_byte) cnt_q <= cnt_q + 2'd1;
        end
        LAST:    res_q[cap_idx +: 8] <= bus.rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_req_o = 1'b0;
    bus.req     = 1'b0;
    bus.addr    = '0;
    bus.wr      = 1'b0;
    bus.wdata   = '0;
    w_addr_o    = NOP_REG_ADDR;
    w_req_o     = 1'b0;
    w_data_o    = '0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_req_o = 1'b1;
          bus.req     = 1'b1;
          if (bus.gnt) state_d = XFER;
        end else begin
          w_addr_o = w_addr_i;
          w_req_o  = w_req_i;
          w_data_o = w_data_i;
        end
      end
      XFER: begin
        stall_req_o = 1'b1;
        bus.req     = 1'b1;
        bus.addr    = base_q + REG_BUS'(cnt_q);
        if (is_store(op_q)) begin
          bus.wr    = 1'b1;
          bus.wdata = 8'(data_q >> {cnt_q, 3'b000});
        end
        if (last_byte) state_d = is_store(op_q) ? DONE : LAST;
      end
      LAST: begin
        stall_req_o = 1'b1;
        bus.req     = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        w_addr_o = waddr_q;
        w_req_o  = wreq_q;
        w_data_o = is_load(op_q) ? ext : data_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every output, pass-through included, reads zero while reset is held
    if (rst) begin
      stall_req_o = 1'b0;
      bus.req     = 1'b0;
      bus.addr    = '0;
      bus.wr      = 1'b0;
      bus.wdata   = '0;
      w_addr_o    = NOP_REG_ADDR;
      w_req_o     = 1'b0;
      w_data_o    = '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a byte-wide memory and grant model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  aluop_t      aluop;
  logic [31:0] mem_addr, w_data_in, w_data_out;
  logic [4:0]  w_addr_in, w_addr_out;
  logic        w_req_in, w_req_out, stall;

  mem_stage_if bus ();

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .mem_addr_i  (mem_addr),
    .w_data_i    (w_data_in),
    .w_addr_i    (w_addr_in),
    .w_req_i     (w_req_in),
    .w_addr_o    (w_addr_out),
    .w_req_o     (w_req_out),
    .w_data_o    (w_data_out),
    .stall_req_o (stall),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 KiB memory aliased on addr[9:0]; read data valid one cycle after the address
  logic [7:0] mem [0:1023];
  logic       pl_we;
  logic [9:0] pl_a;
  logic [7:0] pl_d;
  logic [7:0] rd_byte;

  always @(posedge clk) begin
    rd_byte = mem[bus.addr[9:0]];
    if (bus.wr) mem[bus.addr[9:0]] = bus.wdata;
    else if (pl_we) mem[pl_a] = pl_d;
    bus.rdata <= rd_byte;
  end

  int errors = 0;
  int checks = 0;

  int          stall_cycles, wr_cycles, done_cyc;
  logic [31:0] addrs [0:3];
  logic [31:0] done_data;
  logic [4:0]  done_waddr;
  logic        done_req;

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic idle_inputs();
    aluop = EX_NOP; mem_addr = '0; w_data_in = '0; w_addr_in = '0; w_req_in = 1'b0;
    bus.gnt = 1'b0;
  endtask

  // Issues one access (grant after gdelay wait cycles) and records what the DUT does
  task automatic run_access(input aluop_t op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] wa, input int nbytes, input int gdelay);
    int cyc;
    cyc = 0; stall_cycles = 0; wr_cycles = 0; done_cyc = -1;
    done_data = '0; done_waddr = '0; done_req = 1'b0;
    for (int i = 0; i < 4; i++) addrs[i] = '0;
    @(negedge clk);
    aluop = op; mem_addr = addr; w_data_in = data; w_addr_in = wa; w_req_in = 1'b1;
    bus.gnt = (gdelay == 0);
    while (done_cyc < 0 && cyc < 32) begin
      #1;
      if (stall) stall_cycles++;
      if (bus.wr) wr_cycles++;
      if (cyc > gdelay && cyc <= gdelay + nbytes) addrs[cyc-gdelay-1] = bus.addr;
      if (!stall) begin
        done_cyc = cyc; done_data = w_data_out; done_waddr = w_addr_out; done_req = w_req_out;
      end
      @(negedge clk);
      cyc++;
      bus.gnt = (cyc >= gdelay);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; pl_we = 1'b0;
    aluop = EX_LW; mem_addr = 32'h100; w_data_in = 32'h55; w_addr_in = 5'd9; w_req_in = 1'b1;
    bus.gnt = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.req); end
    checks++; if (bus.wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", bus.wr); end
    checks++; if (w_req_out !== 1'b0) begin errors++; $display("FAIL reset_wreq: got %b want 0", w_req_out); end
    aluop = EX_NOP;
    #1;
    checks++; if (w_data_out !== 32'h0) begin errors++; $display("FAIL reset_pass_data: got %h want 0", w_data_out); end
    checks++; if (w_addr_out !== 5'd0) begin errors++; $display("FAIL reset_pass_addr: got %0d want 0", w_addr_out); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    aluop = EX_NOP; w_data_in = 32'hDEADBEEF; w_addr_in = 5'd9; w_req_in = 1'b1;
    #1;
    checks++; if (w_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL pass_data: got %h want deadbeef", w_data_out); end
    checks++; if (w_addr_out !== 5'd9) begin errors++; $display("FAIL pass_addr: got %0d want 9", w_addr_out); end
    checks++; if (w_req_out !== 1'b1) begin errors++; $display("FAIL pass_req: got %b want 1", w_req_out); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b want 0", stall); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL pass_memreq: got %b want 0", bus.req); end
    idle_inputs();
  endtask

  task automatic test_lw();
    poke(10'h100, 8'h78); poke(10'h101, 8'h56); poke(10'h102, 8'h34); poke(10'h103, 8'h12);
    run_access(EX_LW, 32'h100, 32'h0, 5'd5, 4, 0);
    checks++; if (done_cyc !== 6) begin errors++; $display("FAIL lw_done_cycle: got %0d want 6", done_cyc); end
    checks++; if (stall_cycles !== 6) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 6", stall_cycles); end
    checks++; if (wr_cycles !== 0) begin errors++; $display("FAIL lw_wr_cycles: got %0d want 0", wr_cycles); end
    checks++; if (done_data !== 32'h12345678) begin errors++; $display("FAIL lw_data: got %h want 12345678", done_data); end
    checks++; if (done_waddr !== 5'd5) begin errors++; $display("FAIL lw_waddr: got %0d want 5", done_waddr); end
    checks++; if (done_req !== 1'b1) begin errors++; $display("FAIL lw_wreq: got %b want 1", done_req); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addrs[i] !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL lw_addr%0d: got %h want %h", i, addrs[i], 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_byte_half();
    poke(10'h040, 8'h80); poke(10'h050, 8'h01); poke(10'h051, 8'h80);
    run_access(EX_LB, 32'h40, 32'h0, 5'd6, 1, 0);
    checks++; if (done_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", done_data); end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL lb_done_cycle: got %0d want 3", done_cyc); end
    checks++; if (addrs[0] !== 32'h40) begin errors++; $display("FAIL lb_addr: got %h want 00000040", addrs[0]); end
    run_access(EX_LBU, 32'h40, 32'h0, 5'd6, 1, 0);
    checks++; if (done_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", done_data); end
    run_access(EX_LH, 32'h50, 32'h0, 5'd7, 2, 0);
    checks++; if (done_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", done_data); end
    checks++; if (done_cyc !== 4) begin errors++; $display("FAIL lh_done_cycle: got %0d want 4", done_cyc); end
    run_access(EX_LHU, 32'h50, 32'h0, 5'd7, 2, 0);
    checks++; if (done_data !== 32'h00008001) begin errors++; $display("FAIL lhu_data: got %h want 00008001", done_data); end
  endtask

  task automatic test_store_delayed();
    poke(10'h200, 8'h00); poke(10'h201, 8'h00); poke(10'h202, 8'hEE);
    // Grant arrives in the third cycle: two wait cycles, grant, two XFER, DONE
    run_access(EX_SH, 32'h200, 32'hABCD1234, 5'd8, 2, 2);
    checks++; if (wr_cycles !== 2) begin errors++; $display("FAIL sh_wr_cycles: got %0d want 2", wr_cycles); end
    checks++; if (stall_cycles !== 5) begin errors++; $display("FAIL sh_stall_cycles: got %0d want 5", stall_cycles); end
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL sh_done_cycle: got %0d want 5", done_cyc); end
    checks++; if (mem[10'h200] !== 8'h34) begin errors++; $display("FAIL sh_byte0: got %h want 34", mem[10'h200]); end
    checks++; if (mem[10'h201] !== 8'h12) begin errors++; $display("FAIL sh_byte1: got %h want 12", mem[10'h201]); end
    checks++; if (mem[10'h202] !== 8'hEE) begin errors++; $display("FAIL sh_byte2_untouched: got %h want ee", mem[10'h202]); end
    checks++; if (done_data !== 32'hABCD1234) begin errors++; $display("FAIL sh_wdata: got %h want abcd1234", done_data); end
  endtask

  task automatic test_wrap();
    poke(10'h3FE, 8'hAA); poke(10'h3FF, 8'hBB); poke(10'h000, 8'hCC); poke(10'h001, 8'hDD);
    run_access(EX_LW, 32'hFFFFFFFE, 32'h0, 5'd10, 4, 0);
    checks++; if (addrs[0] !== 32'hFFFFFFFE) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffe", addrs[0]); end
    checks++; if (addrs[1] !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_addr1: got %h want ffffffff", addrs[1]); end
    checks++; if (addrs[2] !== 32'h0) begin errors++; $display("FAIL wrap_addr2: got %h want 00000000", addrs[2]); end
    checks++; if (addrs[3] !== 32'h1) begin errors++; $display("FAIL wrap_addr3: got %h want 00000001", addrs[3]); end
    checks++; if (done_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL wrap_data: got %h want ddccbbaa", done_data); end
  endtask

  task automatic test_reset_mid_store();
    poke(10'h300, 8'h00); poke(10'h301, 8'h5A);
    @(negedge clk);
    aluop = EX_SW; mem_addr = 32'h300; w_data_in = 32'h11223344; w_addr_in = 5'd4; w_req_in = 1'b1;
    bus.gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.wr !== 1'b1 || bus.addr !== 32'h301) begin
      errors++; $display("FAIL rstmid_pre: wr=%b addr=%h want wr=1 addr=00000301", bus.wr, bus.addr);
    end
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    checks++; if (bus.wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr: got %b want 0", bus.wr); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", bus.req); end
    checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", bus.addr); end
    checks++; if (bus.wdata !== 8'h0) begin errors++; $display("FAIL rstmid_wdata: got %h want 0", bus.wdata); end
    checks++; if (mem[10'h300] !== 8'h44) begin errors++; $display("FAIL rstmid_byte0: got %h want 44", mem[10'h300]); end
    aluop = EX_NOP; w_data_in = 32'd7; w_addr_in = 5'd3; bus.gnt = 1'b0;
    #1;
    checks++; if (w_data_out !== 32'h0) begin errors++; $display("FAIL rstmid_pass_gated: got %h want 0", w_data_out); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem[10'h301] !== 8'h5A) begin errors++; $display("FAIL rstmid_byte1_kept: got %h want 5a", mem[10'h301]); end
    checks++; if (w_data_out !== 32'd7 || w_addr_out !== 5'd3 || w_req_out !== 1'b1) begin
      errors++; $display("FAIL rstmid_add: got data=%h addr=%0d req=%b want 7/3/1", w_data_out, w_addr_out, w_req_out);
    end
    @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0 || w_data_out !== 32'd7) begin
      errors++; $display("FAIL rstmid_idle: got stall=%b data=%h want 0/7", stall, w_data_out);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    run_access(EX_LW, 32'h100, 32'h0, 5'd2, 4, 0);
    checks++; if (done_data !== 32'h12345678) begin errors++; $display("FAIL b2b_lw_data: got %h want 12345678", done_data); end
    aluop = EX_NOP; w_data_in = 32'd7; w_addr_in = 5'd3; w_req_in = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", stall); end
    checks++; if (w_data_out !== 32'd7) begin errors++; $display("FAIL b2b_data: got %h want 7", w_data_out); end
    checks++; if (w_addr_out !== 5'd3) begin errors++; $display("FAIL b2b_addr: got %0d want 3", w_addr_out); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL b2b_memreq: got %b want 0", bus.req); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_byte_half();
    test_store_delayed();
    test_wrap();
    test_reset_mid_store();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
